// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Multi-cycle division sequencer for the EX stage. Runs a 32-step
//            radix-2 restoring division for DIV/DIVU and holds a stall
//            request until the 64-bit {remainder, quotient} result is ready.
//            A pipeline flush (annul_i) cancels an in-flight operation.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            start_i    - division request, held by EX until ready_o
//            signed_i   - 1 = DIV (two's complement), 0 = DIVU
//            opdata1_i  - dividend (sampled in IDLE only)
//            opdata2_i  - divisor  (sampled in IDLE only)
//            annul_i    - cancel the in-flight operation
//            stallreq_o - stall request to the pipeline controller
//            result_o   - {remainder[63:32], quotient[31:0]}
//            ready_o    - result_o is valid
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        annul_i,
   output logic        stallreq_o,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BY_ZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } state_t;

   localparam logic [5:0] c_LAST_STEP = 6'd31;

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [64:0] r_w;        // {partial remainder, dividend/quotient}
   logic [31:0] r_divisor;  // |divisor|
   logic        r_negq;
   logic        r_negr;
   logic [63:0] r_result;
   logic        r_ready;

   logic [31:0] w_abs1;
   logic [31:0] w_abs2;
   logic [64:0] w_shift;
   logic [33:0] w_trial;
   logic [64:0] w_step;
   logic [31:0] w_rem;
   logic [31:0] w_quo;
   logic [63:0] w_final;

   // Magnitudes are only taken for signed operations.
   assign w_abs1 = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_abs2 = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // One restoring step: shift left, trial subtract, set the quotient LSB.
   // The partial remainder is always below the divisor, so bit 64 of r_w
   // stays zero and serves as the sign-extension bit of the 34-bit trial.
   assign w_shift = {r_w[63:0], 1'b0};
   assign w_trial = r_w[64:31] - {2'b00, r_divisor};
   assign w_step  = w_trial[33] ? w_shift : {w_trial[32:0], r_w[30:0], 1'b1};

   assign w_rem   = w_step[63:32];
   assign w_quo   = w_step[31:0];
   assign w_final = {r_negr ? (~w_rem + 32'd1) : w_rem,
                     r_negq ? (~w_quo + 32'd1) : w_quo};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 6'd0;
         r_w       <= 65'd0;
         r_divisor <= 32'd0;
         r_negq    <= 1'b0;
         r_negr    <= 1'b0;
         r_result  <= 64'd0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // annul_i outranks start_i here.
               if (!annul_i && start_i) begin
                  if (opdata2_i == 32'd0) begin
                     r_state <= S_BY_ZERO;
                  end else begin
                     r_divisor <= w_abs2;
                     r_w       <= {33'd0, w_abs1};
                     r_cnt     <= 6'd0;
                     r_negq    <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                     r_negr    <= signed_i & opdata1_i[31];
                     r_state   <= S_ON;
                  end
               end
            end

            S_BY_ZERO: begin
               if (annul_i) begin
                  r_state  <= S_IDLE;
                  r_cnt    <= 6'd0;
                  r_result <= 64'd0;
                  r_ready  <= 1'b0;
               end else begin
                  r_result <= 64'd0;
                  r_ready  <= 1'b1;
                  r_state  <= S_END;
               end
            end

            S_ON: begin
               if (annul_i) begin
                  r_state  <= S_IDLE;
                  r_cnt    <= 6'd0;
                  r_result <= 64'd0;
                  r_ready  <= 1'b0;
               end else begin
                  r_w   <= w_step;
                  r_cnt <= r_cnt + 6'd1;
                  if (r_cnt == c_LAST_STEP) begin
                     r_result <= w_final;
                     r_ready  <= 1'b1;
                     r_state  <= S_END;
                  end
               end
            end

            S_END: begin
               // Result is held for as long as EX keeps start_i asserted.
               if (annul_i || !start_i) begin
                  r_state  <= S_IDLE;
                  r_cnt    <= 6'd0;
                  r_result <= 64'd0;
                  r_ready  <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign stallreq_o = start_i & ~r_ready & ~annul_i;
   assign result_o   = r_result;
   assign ready_o    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Purpose  : Self-checking bench for div_ctrl. Expected results are pushed
//            to a scoreboard queue when a division is started and popped
//            when ready_o rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        annul_i;
   logic        stallreq_o;
   logic [63:0] result_o;
   logic        ready_o;

   int          n_vec;
   int          n_err;
   logic [63:0] sb_q[$];

   div_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .opdata1_i  (opdata1_i),
      .opdata2_i  (opdata2_i),
      .annul_i    (annul_i),
      .stallreq_o (stallreq_o),
      .result_o   (result_o),
      .ready_o    (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: divide magnitudes, then apply MIPS sign rules.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      logic [31:0] ma, mb, q, r;
      if (b == 32'd0) return 64'd0;
      ma = (sgn && a[31]) ? 32'd0 - a : a;
      mb = (sgn && b[31]) ? 32'd0 - b : b;
      q  = ma / mb;
      r  = ma % mb;
      if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
      if (sgn && a[31])           r = 32'd0 - r;
      return {r, q};
   endfunction

   // Drive a request just after a rising edge; that cycle is cycle 0.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input bit push, input logic [63:0] exp);
      @(posedge clk);
      #1;
      start_i   = 1'b1;
      signed_i  = sgn;
      opdata1_i = a;
      opdata2_i = b;
      if (push) sb_q.push_back(exp);
   endtask

   // Wait for ready_o, check latency/stall length/result, optionally release.
   task automatic wait_done(input string tag, input int exp_lat, input int exp_stall, input bit release_start);
      int  lat;
      int  stalls;
      bit  got;
      logic [63:0] exp;
      lat = 0; stalls = 0; got = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (ready_o) begin
            lat = c; got = 1;
            break;
         end
         if (stallreq_o) stalls++;
      end
      if (!got) begin
         check({tag, "_timeout"}, 64'd0, 64'd1);
         return;
      end
      // Scrambling opdata after IDLE must not disturb anything.
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         exp = sb_q.pop_front();
         check({tag, "_result"}, result_o, exp);
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
      if (release_start) begin
         @(posedge clk);
         #1 start_i = 1'b0;
         @(negedge clk);
         check({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
         @(negedge clk);
         check({tag, "_rel_ready"}, {63'd0, ready_o}, 64'd0);
         check({tag, "_rel_result"}, result_o, 64'd0);
      end
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      int          rdy_cnt;
      n_vec = 0; n_err = 0;
      rst = 1'b1; start_i = 1'b0; signed_i = 1'b0;
      opdata1_i = 32'd0; opdata2_i = 32'd0; annul_i = 1'b0;
      #1;
      check("reset_result", result_o, 64'd0);
      check("reset_ready", {63'd0, ready_o}, 64'd0);
      check("reset_stall", {63'd0, stallreq_o}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      start_op(32'd100, 32'd7, 1'b0, 1, {32'd2, 32'd14});
      wait_done("u100_7", 33, 33, 1);
      start_op(32'hFFFFFFF9, 32'd2, 1'b1, 1, {32'hFFFFFFFF, 32'hFFFFFFFD});
      wait_done("s-7_2", 33, 33, 1);
      start_op(32'd7, 32'hFFFFFFFE, 1'b1, 1, {32'h00000001, 32'hFFFFFFFD});
      wait_done("s7_-2", 33, 33, 1);
      start_op(32'd5, 32'd0, 1'b0, 1, 64'd0);
      wait_done("div0", 2, 2, 1);
      start_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, {32'h0, 32'h80000000});
      wait_done("s_min_neg1", 33, 33, 1);
      start_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1, {32'h80000000, 32'h0});
      wait_done("u_min_neg1", 33, 33, 1);

      // Random vectors against the reference model
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (b == 32'd0) b = 32'd3;
         s = i[0] ^ i[1];
         start_op(a, b, s, 1, model(a, b, s));
         wait_done("rand", 33, 33, 1);
      end

      // Annul in cycle 10
      start_op(32'd100, 32'd7, 1'b0, 0, 64'd0);
      repeat (10) @(posedge clk);
      #1 annul_i = 1'b1;
      @(negedge clk);
      check("annul_stall", {63'd0, stallreq_o}, 64'd0);
      @(posedge clk);
      #1; annul_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      check("annul_idle", {62'd0, dut.r_state}, 64'd0);
      check("annul_result", result_o, 64'd0);
      rdy_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready_o) rdy_cnt++;
      end
      check("annul_no_ready", 64'(rdy_cnt), 64'd0);

      // Async reset in cycle 15 of a division
      start_op(32'd100, 32'd7, 1'b0, 0, 64'd0);
      repeat (15) @(posedge clk);
      #1;
      check("pre_rst_on", {62'd0, dut.r_state}, 64'd2);
      #2; rst = 1'b1; start_i = 1'b0;
      #1;
      check("arst_idle", {62'd0, dut.r_state}, 64'd0);
      check("arst_ready", {63'd0, ready_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      start_op(32'd100, 32'd7, 1'b0, 1, {32'd2, 32'd14});
      wait_done("post_rst", 33, 33, 1);

      // Async reset while a non-zero result is held in END
      start_op(32'd1000, 32'd3, 1'b0, 1, {32'd1, 32'd333});
      wait_done("end_hold", 33, 33, 0);
      #1 rst = 1'b1;
      #1;
      check("arst_end_result", result_o, 64'd0);
      check("arst_end_ready", {63'd0, ready_o}, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard stop in case a wait escapes its bound.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
